// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the instruction-fetch stage.
//   fetch_state_e    : fetch FSM states (IDLE, FETCH, WAIT, FAULT)
//   PC_HOLE_MASK     : reserved PC bits [11:10], must always read 00
//   DEFAULT_RESET_PC : default PC after reset
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [15:0] PC_HOLE_MASK     = 16'h0C00;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

  function automatic logic [15:0] clear_hole(input logic [15:0] addr);
    return addr & ~PC_HOLE_MASK;
  endfunction

  function automatic logic hits_hole(input logic [15:0] addr);
    return |(addr & PC_HOLE_MASK);
  endfunction

endpackage

// File: rtl/fetch_unit_skid.sv
// fetch_skid_buf: one-entry 16-bit holding buffer with a valid flag.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : capture data_i and mark the entry valid
//   drain_i      : invalidate the entry (wins over load_i)
//   data_o       : buffered word
//   valid_o      : entry holds a word
module fetch_skid_buf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic [15:0] data_i,
  output logic [15:0] data_o,
  output logic        valid_o
);

  logic [15:0] data_q;
  logic        valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (load_i) begin
        data_q <= data_i;
      end
      if (drain_i) begin
        valid_q <= 1'b0;
      end else if (load_i) begin
        valid_q <= 1'b1;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Holds the architectural PC, fetches
// through a req/ack handshake and presents words to decode via IR plus a
// one-entry skid buffer.
//   CLK, Reset        : clock, asynchronous active-high reset
//   PC / PCinc        : current fetch address / incremented PC from incrementer
//   branch_en/_target : redirect pulse and target
//   imem_req/_addr    : fetch request and address (address always equals PC)
//   imem_ack/_data    : memory response and fetched word
//   IR, ir_valid      : instruction to decode and its valid flag
//   stall             : decode cannot consume IR this cycle
//   addr_fault        : sticky illegal-redirect flag
// Build option FETCH_ADDR_CHECK_EN: a redirect into the PC hole faults instead
// of having bits [11:10] cleared.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [15:0] PC,
  input  logic [15:0] PCinc,
  input  logic        branch_en,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] IR,
  output logic        ir_valid,
  input  logic        stall,
  output logic        addr_fault
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  ir_q, ir_d;
  logic         ir_valid_q, ir_valid_d;
  logic         pend_valid_q, pend_valid_d;
  logic [15:0]  pend_target_q, pend_target_d;

  logic         skid_load, skid_drain, skid_valid;
  logic [15:0]  skid_data;

  logic         consume;
  logic         target_bad;
  logic [15:0]  target_fix;

`ifdef FETCH_ADDR_CHECK_EN
  assign target_bad = hits_hole(branch_target);
  assign target_fix = branch_target;
`else
  assign target_bad = 1'b0;
  assign target_fix = clear_hole(branch_target);
`endif

  assign consume = ir_valid_q && !stall;

  fetch_skid_buf u_skid (
    .clk_i   (CLK),
    .rst_i   (Reset),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .data_i  (imem_data),
    .data_o  (skid_data),
    .valid_o (skid_valid)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    ir_valid_d    = ir_valid_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    skid_load     = 1'b0;
    skid_drain    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        if (branch_en) begin
          if (target_bad) begin
            state_d = ST_FAULT;
          end else begin
            pc_d = target_fix;
          end
        end
      end

      ST_FETCH: begin
        if (branch_en && target_bad) begin
          state_d      = ST_FAULT;
          ir_valid_d   = 1'b0;
          skid_drain   = 1'b1;
          pend_valid_d = 1'b0;
        end else if (imem_ack) begin
          if (branch_en || pend_valid_q) begin
            // Word belongs to the abandoned path: drop it and redirect.
            pc_d         = branch_en ? target_fix : pend_target_q;
            pend_valid_d = 1'b0;
            ir_valid_d   = 1'b0;
            skid_drain   = 1'b1;
          end else begin
            pc_d = PCinc;
            if (!ir_valid_q || !stall) begin
              ir_d       = imem_data;
              ir_valid_d = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_d   = ST_WAIT;
            end
          end
        end else if (branch_en) begin
          // PC must hold while the request is outstanding; apply at the ack.
          pend_valid_d  = 1'b1;
          pend_target_d = target_fix;
          ir_valid_d    = 1'b0;
          skid_drain    = 1'b1;
        end else if (consume) begin
          ir_valid_d = 1'b0;
        end
      end

      ST_WAIT: begin
        if (branch_en) begin
          ir_valid_d = 1'b0;
          skid_drain = 1'b1;
          if (target_bad) begin
            state_d = ST_FAULT;
          end else begin
            pc_d    = target_fix;
            state_d = ST_FETCH;
          end
        end else if (consume && skid_valid) begin
          ir_d       = skid_data;
          skid_drain = 1'b1;
          state_d    = ST_FETCH;
        end
      end

      ST_FAULT: begin
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      ir_q          <= '0;
      ir_valid_q    <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      ir_valid_q    <= ir_valid_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign PC        = pc_q;
  assign imem_addr = pc_q;
  assign imem_req  = (state_q == ST_FETCH);
  assign IR        = ir_q;
  assign ir_valid  = ir_valid_q;

`ifdef FETCH_ADDR_CHECK_EN
  // FAULT is only left through Reset, so the state itself is the sticky flag.
  assign addr_fault = (state_q == ST_FAULT);
`else
  assign addr_fault = 1'b0;
`endif

endmodule
